// File: rtl/tbus_arbiter.sv
// Round-robin arbiter for a tribuf-based shared bus: one-hot registered grants,
// a forced all-off turnaround gap between owners, and a capped tenure when others wait.
module tbus_arbiter #(
  parameter int N     = 4,
  parameter int MAXT  = 8,
  parameter int TURNC = 1,
  parameter int IW    = $clog2(N)
) (
  input  logic          CK,
  input  logic          RST,
  input  logic [N-1:0]  REQ,
  output logic [N-1:0]  GNT,
  output logic          BUSY,
  output logic [IW-1:0] OWNER
);

  localparam int CW = $clog2(MAXT + 1);
  localparam int TW = $clog2(TURNC + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAXT);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURNC - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN  = 2'd1;
  localparam logic [1:0] TURN = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic           found;
  logic [IW-1:0]  off;
  logic [IW:0]    sum;
  logic [IW-1:0]  win;
  logic [N-1:0]   win_onehot;

  // Rotate REQ so that index ptr sits at bit 0; the lowest set bit of the
  // rotated vector is the round-robin winner, mapped back modulo N.
  always_comb begin
    dbl   = {REQ, REQ} >> ptr;
    rot   = dbl[N-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IW'(k);
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (IW+1)'(N))
      sum = sum - (IW+1)'(N);
    win        = sum[IW-1:0];
    win_onehot = N'(1) << win;
  end

  logic          owner_req;
  logic          others_req;
  logic          release_now;
  logic [IW-1:0] next_ptr;

  // GNT is one-hot during OWN, so it doubles as the owner mask.
  always_comb begin
    owner_req   = |(REQ & GNT);
    others_req  = |(REQ & ~GNT);
    release_now = !owner_req || ((cnt == CNT_MAX) && others_req);
    next_ptr    = (OWNER == IW'(N - 1)) ? '0 : OWNER + IW'(1);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state <= IDLE;
      GNT   <= '0;
      BUSY  <= 1'b0;
      OWNER <= '0;
      ptr   <= '0;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            GNT   <= win_onehot;
            BUSY  <= 1'b1;
            OWNER <= win;
            cnt   <= CW'(1);
            state <= OWN;
          end
        end
        OWN: begin
          if (release_now) begin
            GNT   <= '0;
            BUSY  <= 1'b0;
            ptr   <= next_ptr;
            tcnt  <= '0;
            state <= TURN;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
          end
        end
        TURN: begin
          // Requests raised during the gap are still eligible at its last edge.
          if (tcnt != TURN_LAST) begin
            tcnt <= tcnt + TW'(1);
          end else if (found) begin
            GNT   <= win_onehot;
            BUSY  <= 1'b1;
            OWNER <= win;
            cnt   <= CW'(1);
            state <= OWN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          GNT   <= '0;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbus_arbiter.sv
// Scoreboard bench for tbus_arbiter: instance a uses TURNC=1, instance b TURNC=3.
// Each stimulus cycle queues the hand-computed post-edge response for its instance.
module tb_tbus_arbiter;

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] req_a = 4'b0000;
  logic [3:0] req_b = 4'b0000;
  logic [3:0] gnt_a, gnt_b;
  logic       busy_a, busy_b;
  logic [1:0] owner_a, owner_b;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] owner;
    string      tag;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  always #5 CK = ~CK;

  tbus_arbiter #(.N(4), .MAXT(8), .TURNC(1)) dut_a (
    .CK(CK), .RST(RST), .REQ(req_a), .GNT(gnt_a), .BUSY(busy_a), .OWNER(owner_a)
  );

  tbus_arbiter #(.N(4), .MAXT(8), .TURNC(3)) dut_b (
    .CK(CK), .RST(RST), .REQ(req_b), .GNT(gnt_b), .BUSY(busy_b), .OWNER(owner_b)
  );

  task automatic applyStimulus(input bit sel, input logic rst_v, input logic [3:0] req_v,
                               input logic [3:0] g, input logic [1:0] o, input string tag);
    exp_t e;
    @(negedge CK);
    RST = rst_v;
    e.gnt = g;
    e.owner = o;
    e.tag = tag;
    if (sel == 1'b0) begin
      req_a = req_v;
      qa.push_back(e);
    end else begin
      req_b = req_v;
      qb.push_back(e);
    end
  endtask

  task automatic checkOutput(input string dut, input exp_t e, input logic [3:0] g,
                             input logic b, input logic [1:0] o);
    total += 4;
    if (g !== e.gnt) begin
      bad++;
      $display("[TB] FAIL %s/%s gnt: got %b want %b", dut, e.tag, g, e.gnt);
    end
    if (b !== (|e.gnt)) begin
      bad++;
      $display("[TB] FAIL %s/%s busy: got %b want %b", dut, e.tag, b, |e.gnt);
    end
    if (o !== e.owner) begin
      bad++;
      $display("[TB] FAIL %s/%s owner: got %0d want %0d", dut, e.tag, o, e.owner);
    end
    if (!$onehot0(g)) begin
      bad++;
      $display("[TB] FAIL %s/%s onehot0: got %b want at most one bit", dut, e.tag, g);
    end
  endtask

  always @(posedge CK) begin
    #1;
    if (qa.size() > 0) begin
      ea = qa.pop_front();
      checkOutput("a", ea, gnt_a, busy_a, owner_a);
    end
  end

  always @(posedge CK) begin
    #1;
    if (qb.size() > 0) begin
      eb = qb.pop_front();
      checkOutput("b", eb, gnt_b, busy_b, owner_b);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting tbus_arbiter bench");

    // Reset with all requesting, then first grant right after release of reset.
    applyStimulus(0, 1, 4'b1111, 4'b0000, 2'd0, "rst_hold");
    applyStimulus(0, 1, 4'b1111, 4'b0000, 2'd0, "rst_hold");
    applyStimulus(0, 0, 4'b1111, 4'b0001, 2'd0, "rst_first");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd0, "rst_drop");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd0, "rst_idle");

    // Single requester 2 for five cycles; ptr is 1 here so scan reaches 2.
    for (int c = 0; c < 5; c++)
      applyStimulus(0, 0, 4'b0100, 4'b0100, 2'd2, "single");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd2, "single_drop");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd2, "single_idle");

    // Round robin with everyone requesting, from a fresh pointer.
    applyStimulus(0, 1, 4'b0000, 4'b0000, 2'd0, "rr_reset");
    for (int o = 0; o < 4; o++) begin
      for (int c = 0; c < 8; c++)
        applyStimulus(0, 0, 4'b1111, 4'(1 << o), 2'(o), "rr_own");
      applyStimulus(0, 0, 4'b1111, 4'b0000, 2'(o), "rr_gap");
    end
    applyStimulus(0, 0, 4'b1111, 4'b0001, 2'd0, "rr_wrap");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd0, "rr_drop");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd0, "rr_idle");

    // Lone owner keeps the bus past MAXT; a late waiter forces handover.
    for (int c = 0; c < 20; c++)
      applyStimulus(0, 0, 4'b0010, 4'b0010, 2'd1, "sat_hold");
    applyStimulus(0, 0, 4'b1010, 4'b0000, 2'd1, "sat_release");
    applyStimulus(0, 0, 4'b1010, 4'b1000, 2'd3, "sat_handover");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd3, "sat_drop");
    applyStimulus(0, 0, 4'b0000, 4'b0000, 2'd3, "sat_idle");

    // Three-cycle turnaround on instance b; REQ[2] arriving mid-gap loses to 1.
    applyStimulus(1, 0, 4'b0001, 4'b0001, 2'd0, "turn_own0");
    applyStimulus(1, 0, 4'b0011, 4'b0001, 2'd0, "turn_wait1");
    applyStimulus(1, 0, 4'b0010, 4'b0000, 2'd0, "turn_gap1");
    applyStimulus(1, 0, 4'b0110, 4'b0000, 2'd0, "turn_gap2");
    applyStimulus(1, 0, 4'b0110, 4'b0000, 2'd0, "turn_gap3");
    applyStimulus(1, 0, 4'b0110, 4'b0010, 2'd1, "turn_own1");
    applyStimulus(1, 0, 4'b0100, 4'b0000, 2'd1, "turn_rel1");
    applyStimulus(1, 0, 4'b0100, 4'b0000, 2'd1, "turn_gap");
    applyStimulus(1, 0, 4'b0100, 4'b0000, 2'd1, "turn_gap");
    applyStimulus(1, 0, 4'b0100, 4'b0100, 2'd2, "turn_own2");

    // Reset while 2 owns: grant drops, pointer returns to 0 so 0 beats 2.
    applyStimulus(1, 1, 4'b0101, 4'b0000, 2'd0, "midrst");
    applyStimulus(1, 0, 4'b0101, 4'b0001, 2'd0, "midrst_regrant");
    applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd0, "midrst_drop");
    applyStimulus(1, 0, 4'b0000, 4'b0000, 2'd0, "midrst_idle");

    @(posedge CK);
    #3;
    total++;
    if (qa.size() + qb.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain: got %0d pending want 0", qa.size() + qb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tbus_arbiter.md
# tbus_arbiter

Round-robin arbiter for a shared tri-state bus built from `tribuf` cells. It accepts up to N request lines and drives one-hot registered grants, which connect directly to the `E` pins of each requester's `tribuf` driver stage. Between owners it enforces a guaranteed all-off turnaround gap, so two drivers are never enabled in the same cycle. It caps ownership tenure when other requesters are waiting.

## Interface
Parameters:
- N, 4: number of requesters (2..8).
- MAXT, 8: maximum tenure in cycles while others wait (>=1).
- TURNC, 1: turnaround cycles with all grants low between owners (>=1).
- IW, clog2(N): width of OWNER.

Ports:
- CK  input  1  clock; all state changes on rising edge.
- RST  input  1  reset; synchronous, active-high.
- REQ  input  N  request per requester; level-sensitive, held while bus wanted.
- GNT  output  N  one-hot-or-zero registered grant; GNT[i] drives requester i tribuf E.
- BUSY  output  1  OR of GNT, registered.
- OWNER  output  IW  index of current or last owner.

## Operation
- States: IDLE, OWN, TURN. Internal registers: PTR (IW bits, round-robin start), CNT (tenure counter, saturating at MAXT), TCNT (turnaround counter).
- Arbitration: scan REQ starting at index PTR, then PTR+1 and upward, wrapping modulo N. The first set bit wins.
- IDLE:
  - If REQ is all zero, stay in IDLE.
  - Otherwise the winner w gets GNT=onehot(w), OWNER=w, CNT=1. Next state is OWN.
- OWN, owner o:
  - Release condition: REQ[o]==0, or (CNT==MAXT and any REQ[j] with j!=o).
  - On release: GNT=0, BUSY=0, PTR=(o+1) mod N, TCNT=0. Next state is TURN.
  - Otherwise hold the grant. CNT increments and saturates at MAXT.
  - When CNT==MAXT and no other request is pending, ownership continues indefinitely.
- TURN:
  - GNT stays 0.
  - If TCNT<TURNC-1, increment TCNT.
  - If TCNT==TURNC-1, arbitrate exactly as in IDLE: grant to OWN, or go to IDLE if no request.
- OWNER holds its last value outside OWN.
- GNT is never multi-hot. No cycle ever has a GNT bit changing from one requester directly to another.
- Reset:
  - State IDLE; GNT=0, BUSY=0, OWNER=0, PTR=0, CNT=0, TCNT=0.
  - Reset during OWN drops GNT at that edge. No turnaround is applied; the next grant can occur on the first edge after RST deasserts.

## Timing
- Grant latency from IDLE: REQ sampled high at edge k gives GNT high after edge k. Requester sees the grant in the cycle after it first presented REQ.
- Release latency: owner REQ sampled low at edge k gives GNT low after edge k. The owner must not drive the bus in the cycle after lowering REQ unless GNT is still high.
- Handover gap: when a waiter is present, exactly TURNC cycles with GNT=0 occur between the last cycle of owner A and the first cycle of owner B.
- Tenure: with another requester waiting, an owner holds the grant for at most MAXT cycles.
- The waiting requester's REQ must stay asserted; a dropped REQ simply loses the arbitration.
- Simultaneous events:
  - Owner drop and tenure expiry at the same edge are treated as one release.
  - A REQ asserted during TURN is eligible at the final TURN edge.
- Fairness: PTR advances only on release, so every continuously requesting input is granted within (N-1)*(MAXT+TURNC) cycles.

## Test plan
- Reset/idle: RST=1 for 2 cycles with REQ=4'b1111 → GNT=0, BUSY=0, OWNER=0. After RST falls, the first edge gives GNT=4'b0001.
- Single requester: REQ=4'b0100 for 5 cycles, then 0 → GNT=4'b0100 for 5 cycles starting one edge after REQ rises, OWNER=2, then GNT=0 one edge after REQ falls.
- Round robin with all requesting, MAXT=8, TURNC=1 → grant order 0,1,2,3,0. Each grant lasts 8 cycles, separated by exactly 1 zero cycle. GNT is always one-hot or zero.
- Tenure saturation: REQ=4'b0010 held for 20 cycles alone → GNT[1] stays high for all 20 cycles. Raise REQ[3] at cycle 20 → GNT[1] drops at the next edge, 1 gap cycle follows, then GNT=4'b1000.
- Turnaround TURNC=3: owner 0 drops REQ while REQ[1] is waiting → exactly 3 cycles with GNT=0, then GNT=4'b0010. A REQ[2] raised during the gap does not preempt requester 1 (PTR=1).
- Reset mid-ownership: RST pulsed while GNT=4'b0100 → GNT=0 after that edge, PTR=0. With REQ=4'b0101 still held, the grant goes to 0 on the first edge after reset.
